// File: rtl/riscv_cache_pkg.sv
// Shared types for the cache-to-BIU arbiter slice.
//   biu_size_t / biu_prot_t : BIU transfer attributes carried per requester
//   arb_state_t             : arbiter FSM state (ARB, LOCKED)
//   owner_entry_t           : one in-flight transfer {owner, beats remaining - 1}
//   ARB_DCACHE / ARB_ICACHE : requester indices on the arbiter ports
package riscv_cache_pkg;

    // Owner entries are sized for the largest burst the BIU supports;
    // the arbiter's MAX_BURST must not exceed this.
    localparam int BIU_MAX_BURST = 8;
    localparam int BIU_LEN_BITS  = $clog2(BIU_MAX_BURST);

    localparam logic ARB_DCACHE = 1'b0;
    localparam logic ARB_ICACHE = 1'b1;

    typedef enum logic [2:0] {
        BIU_BYTE  = 3'd0,
        BIU_HWORD = 3'd1,
        BIU_WORD  = 3'd2,
        BIU_DWORD = 3'd3,
        BIU_QWORD = 3'd4
    } biu_size_t;

    // {privileged, cacheable/bufferable hint, instruction(1)/data(0)}
    typedef logic [2:0] biu_prot_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                    owner;
        logic [BIU_LEN_BITS-1:0] beats;
    } owner_entry_t;

endpackage

// File: rtl/riscv_cache_biu_arb_if.sv
// Signal bundle between the two cache ports, the arbiter and the BIU.
// Modport slave  : the arbiter (consumes requests, drives acks and BIU command).
// Modport master : the environment (cache ports and BIU).
// Handshake: an address phase is accepted in the cycle where biu_req_o and
// biu_stb_ack_i are both high; the granted requester sees stb_ack_o in that
// same cycle and holds req_i/address fields stable until then. Data beats
// complete on biu_ack_i (or terminate on biu_err_i) and are routed to the
// owner of the oldest outstanding transfer.
interface riscv_cache_biu_arb_if
    import riscv_cache_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int PLEN          = XLEN,
    parameter int LEN_BITS      = 3,
    parameter int INFLIGHT_BITS = 2
) ();

    // cache ports
    logic      [1:0]                    req_i;
    logic      [1:0][PLEN-1:0]          adr_i;
    biu_size_t [1:0]                    size_i;
    biu_prot_t [1:0]                    prot_i;
    logic      [1:0]                    lock_i;
    logic      [1:0]                    we_i;
    logic      [1:0][LEN_BITS-1:0]      len_i;
    logic      [1:0][XLEN-1:0]          d_i;
    logic      [1:0]                    stb_ack_o;
    logic      [1:0]                    ack_o;
    logic      [1:0]                    err_o;
    logic      [XLEN-1:0]               q_o;
    logic      [1:0][INFLIGHT_BITS-1:0] inflight_cnt_o;

    // BIU side
    logic                               biu_req_o;
    logic      [PLEN-1:0]               biu_adr_o;
    biu_size_t                          biu_size_o;
    biu_prot_t                          biu_prot_o;
    logic                               biu_lock_o;
    logic                               biu_we_o;
    logic      [LEN_BITS-1:0]           biu_len_o;
    logic      [XLEN-1:0]               biu_d_o;
    logic                               biu_stb_ack_i;
    logic                               biu_ack_i;
    logic                               biu_err_i;
    logic      [XLEN-1:0]               biu_q_i;

    // arbiter FSM state, for observation only
    arb_state_t                         arb_state_o;

    modport slave (
        input  req_i, adr_i, size_i, prot_i, lock_i, we_i, len_i, d_i,
        input  biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i,
        output stb_ack_o, ack_o, err_o, q_o, inflight_cnt_o,
        output biu_req_o, biu_adr_o, biu_size_o, biu_prot_o, biu_lock_o,
        output biu_we_o, biu_len_o, biu_d_o, arb_state_o
    );

    modport master (
        output req_i, adr_i, size_i, prot_i, lock_i, we_i, len_i, d_i,
        output biu_stb_ack_i, biu_ack_i, biu_err_i, biu_q_i,
        input  stb_ack_o, ack_o, err_o, q_o, inflight_cnt_o,
        input  biu_req_o, biu_adr_o, biu_size_o, biu_prot_o, biu_lock_o,
        input  biu_we_o, biu_len_o, biu_d_o, arb_state_o
    );

endinterface

// File: rtl/riscv_cache_biu_arb_fifo.sv
// Owner FIFO: one entry per accepted address phase, oldest at the head.
//   push_i/push_data_i : append an entry (caller never pushes when full)
//   pop_i              : retire the head entry
//   dec_i              : decrement head.beats (caller never combines with pop_i)
//   full_o/empty_o     : occupancy flags
//   head_o             : oldest entry (undefined content when empty)
module riscv_cache_biu_arb_fifo
    import riscv_cache_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  owner_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         dec_i,
    output logic         full_o,
    output logic         empty_o,
    output owner_entry_t head_o
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    owner_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (dec_i) begin
            mem_d[rd_ptr_q].beats = mem_q[rd_ptr_q].beats - BIU_LEN_BITS'(1);
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CNT_BITS'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_cache_biu_arb.sv
// Shares one BIU between the data-cache port (requester 0) and the
// instruction-cache port (requester 1).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : cache-port requests/acks and the BIU command/data bus
// Address phases are granted round-robin (lock sequences keep the grant),
// every accepted phase is recorded in an owner FIFO, and data-phase
// ack/err/write-data are routed by the FIFO head.
module riscv_cache_biu_arb
    import riscv_cache_pkg::*;
#(
    parameter  int XLEN           = 32,
    parameter  int PLEN           = XLEN,
    parameter  int MAX_BURST      = 8,
    parameter  int INFLIGHT_DEPTH = 2,
    localparam int LEN_BITS       = $clog2(MAX_BURST),
    localparam int INFLIGHT_BITS  = $clog2(INFLIGHT_DEPTH + 1)
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    riscv_cache_biu_arb_if.slave bus
);

    arb_state_t                     state_q, state_d;
    logic                           owner_q, owner_d;
    logic                           prio_q, prio_d;
    logic [1:0][INFLIGHT_BITS-1:0]  cnt_q, cnt_d;

    logic                           gnt;
    logic                           accept;
    logic                           full, empty;
    logic                           pop, dec;
    owner_entry_t                   push_entry, head;
    logic [PLEN-1:0]                adr_mux;
    logic [XLEN-1:0]                wdata_mux;
    logic [LEN_BITS-1:0]            len_mux;
    logic [1:0]                     stb_ack, ack, err;

    // ------------------------------------------------------------------
    // Address phase
    // ------------------------------------------------------------------
    // Priority requester wins if requesting; otherwise the other one.
    always_comb begin
        gnt = prio_q;
        if (state_q == LOCKED) begin
            gnt = owner_q;
        end else if (!bus.req_i[prio_q] && bus.req_i[~prio_q]) begin
            gnt = ~prio_q;
        end
    end

    assign adr_mux = bus.adr_i[gnt];
    assign len_mux = bus.len_i[gnt];

    // A full FIFO blocks requests even if it drains this cycle.
    assign bus.biu_req_o  = bus.req_i[gnt] & ~full;
    assign bus.biu_adr_o  = adr_mux;
    assign bus.biu_size_o = bus.size_i[gnt];
    assign bus.biu_prot_o = bus.prot_i[gnt];
    assign bus.biu_lock_o = bus.lock_i[gnt];
    assign bus.biu_we_o   = bus.we_i[gnt];
    assign bus.biu_len_o  = len_mux;

    assign accept = bus.biu_req_o & bus.biu_stb_ack_i;

    always_comb begin
        stb_ack      = '0;
        stb_ack[gnt] = accept;
    end
    assign bus.stb_ack_o = stb_ack;

    assign push_entry.owner = gnt;
    assign push_entry.beats = BIU_LEN_BITS'(len_mux);

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        // The loser of each acceptance gets priority next time.
        if (accept) begin
            prio_d = ~gnt;
        end
        case (state_q)
            ARB: begin
                if (accept && bus.lock_i[gnt]) begin
                    state_d = LOCKED;
                    owner_d = gnt;
                end
            end
            LOCKED: begin
                if (!bus.req_i[owner_q] || (accept && !bus.lock_i[owner_q])) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            owner_q <= ARB_DCACHE;
            prio_q  <= ARB_DCACHE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.arb_state_o = state_q;

    // ------------------------------------------------------------------
    // Data phase
    // ------------------------------------------------------------------
    riscv_cache_biu_arb_fifo #(
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .dec_i       (dec),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    // BIU responses with nothing outstanding are dropped.
    always_comb begin
        ack = '0;
        err = '0;
        if (!empty) begin
            ack[head.owner] = bus.biu_ack_i;
            err[head.owner] = bus.biu_err_i;
        end
    end

    // An error ends the transfer regardless of remaining beats.
    assign pop = ~empty & (bus.biu_err_i | (bus.biu_ack_i & (head.beats == '0)));
    assign dec = ~empty & bus.biu_ack_i & ~pop;

    assign wdata_mux   = bus.d_i[head.owner];
    assign bus.biu_d_o = wdata_mux;
    assign bus.ack_o   = ack;
    assign bus.err_o   = err;
    assign bus.q_o     = bus.biu_q_i;

    // Increment and decrement applied independently so a same-owner
    // push+pop nets to zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (accept && (gnt == 1'(i))) begin
                cnt_d[i] = cnt_d[i] + INFLIGHT_BITS'(1);
            end
            if (pop && (head.owner == 1'(i))) begin
                cnt_d[i] = cnt_d[i] - INFLIGHT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.inflight_cnt_o = cnt_q;

endmodule
